mem_arbiter: RTL

Shares the single-port, word-wide `memory` block between the instruction-fetch requester and the load/store requester.
- Grants one requester per cycle.
- Sequences sub-word stores as read-modify-write (RMW), because `memory` always writes full words.
- Flags misaligned accesses and returns registered responses.
- Sits between the core's fetch/LSU logic and `memory`.

---
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port, word-wide memory between the
// instruction-fetch requester and the load/store requester.
// Data has priority; a pending fetch denied STARVE_LIMIT cycles in a row
// is forced through. Sub-word stores become a read-modify-write (RMW).
// Optional feature macro: MEM_ARB_STATS_EN adds grant/conflict counters.
//
// Handshake: a requester raises its Req with its other inputs and holds
// them all stable until its Done pulses for one cycle. Results and the
// Misaligned flag are valid only in that Done cycle. A Req still high
// in its Done cycle is a new request, so one access per cycle can be
// sustained. At most one Done pulses in any cycle.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_FetchReq,
  input  logic [31:0] i_FetchAddress,
  output logic        o_FetchDone,
  output logic [31:0] o_FetchData,
  output logic        o_FetchMisaligned,
  input  logic        i_DataReq,
  input  logic        i_DataWrite,
  input  logic [31:0] i_DataAddress,
  input  logic [31:0] i_DataWriteData,
  input  logic [2:0]  i_DataMode,
  output logic        o_DataDone,
  output logic [31:0] o_DataReadData,
  output logic        o_DataMisaligned,
  output logic        o_MemReadEnable,
  output logic        o_MemWriteEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataIn,
  output logic [2:0]  o_MemMode,
  input  logic [31:0] i_MemDataOut,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0] o_FetchGrantCount,
  output logic [31:0] o_DataGrantCount,
  output logic [31:0] o_ConflictCount,
`endif
  output logic        o_DebugState
);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_RMW_WRITE = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [2:0] MODE_WORD  = 3'b010;

  state_t      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic [31:0] rmw_word_q;

  logic        data_mode_ok;
  logic        data_align_ok;
  logic        data_bad;
  logic        fetch_bad;
  logic        in_idle;
  logic        fetch_forced;
  logic        grant_fetch;
  logic        grant_data;
  logic        rmw_active;
  logic [31:0] merged_word;

  assign o_DebugState = state_q;

  // Classify the data request: legal mode for its direction, and aligned to its size
  always_comb begin
    data_mode_ok  = 1'b0;
    data_align_ok = 1'b0;
    if (i_DataWrite) begin
      case (i_DataMode)
        3'b000: begin data_mode_ok = 1'b1; data_align_ok = 1'b1; end
        3'b001: begin data_mode_ok = 1'b1; data_align_ok = ~i_DataAddress[0]; end
        3'b010: begin data_mode_ok = 1'b1; data_align_ok = (i_DataAddress[1:0] == 2'b00); end
        default: ;
      endcase
    end else begin
      case (i_DataMode)
        3'b000, 3'b100: begin data_mode_ok = 1'b1; data_align_ok = 1'b1; end
        3'b001, 3'b101: begin data_mode_ok = 1'b1; data_align_ok = ~i_DataAddress[0]; end
        3'b010:         begin data_mode_ok = 1'b1; data_align_ok = (i_DataAddress[1:0] == 2'b00); end
        default: ;
      endcase
    end
  end

  assign data_bad  = ~(data_mode_ok & data_align_ok);
  assign fetch_bad = |i_FetchAddress[1:0];

  // Reset suppresses every grant so nothing reaches memory while it is held
  assign in_idle      = (state_q == S_IDLE) && !i_Reset;
  assign rmw_active   = (state_q == S_RMW_WRITE) && !i_Reset;
  assign fetch_forced = (starve_q == STARVE_MAX);
  assign grant_fetch  = in_idle && i_FetchReq && (!i_DataReq || fetch_forced);
  assign grant_data   = in_idle && i_DataReq && !grant_fetch;

  // Starve counter: counts denied cycles of a pending fetch, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!i_FetchReq || grant_fetch) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Insert the store byte/half into the word latched during the RMW read
  always_comb begin
    merged_word = rmw_word_q;
    if (i_DataMode[0]) begin
      merged_word[{i_DataAddress[1], 4'b0000} +: 16] = i_DataWriteData[15:0];
    end else begin
      merged_word[{i_DataAddress[1:0], 3'b000} +: 8] = i_DataWriteData[7:0];
    end
  end

  // Memory-side drive, decided from state and the current grant
  always_comb begin
    o_MemReadEnable  = 1'b0;
    o_MemWriteEnable = 1'b0;
    o_MemAddress     = '0;
    o_MemDataIn      = '0;
    o_MemMode        = MODE_WORD;
    if (rmw_active) begin
      o_MemWriteEnable = 1'b1;
      o_MemAddress     = {i_DataAddress[31:2], 2'b00};
      o_MemDataIn      = merged_word;
    end else if (grant_fetch && !fetch_bad) begin
      o_MemReadEnable = 1'b1;
      o_MemAddress    = i_FetchAddress;
    end else if (grant_data && !data_bad) begin
      if (!i_DataWrite) begin
        // Loads pass straight through; memory extracts and extends
        o_MemReadEnable = 1'b1;
        o_MemAddress    = i_DataAddress;
        o_MemMode       = i_DataMode;
      end else if (i_DataMode == MODE_WORD) begin
        o_MemWriteEnable = 1'b1;
        o_MemAddress     = i_DataAddress;
        o_MemDataIn      = i_DataWriteData;
      end else begin
        // First half of RMW: fetch the containing word
        o_MemReadEnable = 1'b1;
        o_MemAddress    = {i_DataAddress[31:2], 2'b00};
      end
    end
  end

  // Arbiter FSM with registered responses and starve counter
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q           <= S_IDLE;
      starve_q          <= '0;
      rmw_word_q        <= '0;
      o_FetchDone       <= 1'b0;
      o_FetchData       <= '0;
      o_FetchMisaligned <= 1'b0;
      o_DataDone        <= 1'b0;
      o_DataReadData    <= '0;
      o_DataMisaligned  <= 1'b0;
    end else begin
      starve_q          <= starve_d;
      o_FetchDone       <= 1'b0;
      o_FetchMisaligned <= 1'b0;
      o_DataDone        <= 1'b0;
      o_DataMisaligned  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_fetch) begin
            o_FetchDone       <= 1'b1;
            o_FetchMisaligned <= fetch_bad;
            o_FetchData       <= fetch_bad ? 32'h0 : i_MemDataOut;
          end else if (grant_data) begin
            if (data_bad) begin
              o_DataDone       <= 1'b1;
              o_DataMisaligned <= 1'b1;
              o_DataReadData   <= '0;
            end else if (!i_DataWrite) begin
              o_DataDone     <= 1'b1;
              o_DataReadData <= i_MemDataOut;
            end else if (i_DataMode == MODE_WORD) begin
              o_DataDone     <= 1'b1;
              o_DataReadData <= '0;
            end else begin
              rmw_word_q <= i_MemDataOut;
              state_q    <= S_RMW_WRITE;
            end
          end
        end
        S_RMW_WRITE: begin
          state_q        <= S_IDLE;
          o_DataDone     <= 1'b1;
          o_DataReadData <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Grant and conflict statistics, free-running and wrapping
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_FetchGrantCount <= '0;
      o_DataGrantCount  <= '0;
      o_ConflictCount   <= '0;
    end else begin
      if (grant_fetch) o_FetchGrantCount <= o_FetchGrantCount + 32'd1;
      if (grant_data)  o_DataGrantCount  <= o_DataGrantCount + 32'd1;
      if (in_idle && i_FetchReq && i_DataReq) o_ConflictCount <= o_ConflictCount + 32'd1;
    end
  end
`endif

endmodule
